sim_term_ctrl: RTL and testbench

Simulation-termination sequencer for the Verilator top. It watches software test-status writes captured by the simulation SRAM interface and walks a boot → test → result state machine. It runs an inactivity watchdog and holds a drain window so UART and DPI output can flush. It then presents a sticky done/pass/timeout result that the top-level `$finish` logic consumes.

---
 rtl/sim_term_ctrl.sv | 145 ++++++++++++++
 tb/tb_sim_term_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_term_ctrl.sv
// Simulation-termination sequencer: tracks software status writes through
// boot/test/result, runs an inactivity watchdog and a drain window, then latches a sticky result.
module sim_term_ctrl #(
   parameter int CntW   = 32,
   parameter int DrainW = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_valid_i,
   input  logic [31:0]       addr_i,
   input  logic [15:0]       data_i,
   input  logic [31:0]       status_addr_i,
   input  logic [CntW-1:0]   timeout_cycles_i,
   input  logic [DrainW-1:0] drain_cycles_i,
   output logic              done_o,
   output logic              passed_o,
   output logic              timeout_o,
   output logic              proto_err_o,
   output logic [2:0]        state_o,
   output logic [15:0]       last_status_o
);

   localparam logic [15:0] CODE_BOOT = 16'hb090;
   localparam logic [15:0] CODE_TEST = 16'h4354;
   localparam logic [15:0] CODE_PASS = 16'h900d;
   localparam logic [15:0] CODE_FAIL = 16'hbaad;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BOOT  = 3'd1,
      ST_TEST  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [CntW-1:0]   cnt_reg, cnt_next;
   logic [DrainW-1:0] dcnt_reg, dcnt_next;
   logic [15:0]       last_reg, last_next;
   logic              done_reg, done_next;
   logic              passed_reg, passed_next;
   logic              timeout_reg, timeout_next;
   logic              proto_reg, proto_next;

   logic running;
   logic accept;
   logic enter_drain;
   logic drain_pass;
   logic drain_to;
   logic drain_proto;

   assign running = (state_reg == ST_IDLE) || (state_reg == ST_BOOT) || (state_reg == ST_TEST);
   assign accept  = running && wr_valid_i && (addr_i == status_addr_i);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      dcnt_next    = dcnt_reg;
      last_next    = last_reg;
      done_next    = done_reg;
      passed_next  = passed_reg;
      timeout_next = timeout_reg;
      proto_next   = proto_reg;
      enter_drain  = 1'b0;
      drain_pass   = 1'b0;
      drain_to     = 1'b0;
      drain_proto  = 1'b0;

      case (state_reg)
         ST_IDLE, ST_BOOT, ST_TEST: begin
            // An accepted write always beats a watchdog expiry in the same cycle.
            if (accept) begin
               last_next = data_i;
               cnt_next  = '0;
               case (data_i)
                  CODE_BOOT: if (state_reg == ST_IDLE) state_next = ST_BOOT;
                  CODE_TEST: if (state_reg != ST_TEST) state_next = ST_TEST;
                  CODE_PASS: begin
                     enter_drain = 1'b1;
                     drain_pass  = (state_reg == ST_TEST);
                     drain_proto = (state_reg != ST_TEST);
                  end
                  CODE_FAIL: enter_drain = 1'b1;
                  default: ;
               endcase
            end else begin
               if (cnt_reg != '1) cnt_next = cnt_reg + CntW'(1);
               if ((timeout_cycles_i != '0) && (cnt_reg == timeout_cycles_i)) begin
                  enter_drain = 1'b1;
                  drain_to    = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (dcnt_reg == '0) begin
               state_next = ST_DONE;
               done_next  = 1'b1;
            end else begin
               dcnt_next = dcnt_reg - DrainW'(1);
            end
         end
         ST_DONE: ;
         default: state_next = ST_IDLE;
      endcase

      // Result flags are written only here, so they freeze once Drain is entered.
      if (enter_drain) begin
         state_next   = ST_DRAIN;
         dcnt_next    = drain_cycles_i;
         passed_next  = drain_pass;
         timeout_next = drain_to;
         proto_next   = drain_proto;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         dcnt_reg    <= '0;
         last_reg    <= '0;
         done_reg    <= 1'b0;
         passed_reg  <= 1'b0;
         timeout_reg <= 1'b0;
         proto_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         dcnt_reg    <= dcnt_next;
         last_reg    <= last_next;
         done_reg    <= done_next;
         passed_reg  <= passed_next;
         timeout_reg <= timeout_next;
         proto_reg   <= proto_next;
      end
   end

   assign done_o        = done_reg;
   assign passed_o      = passed_reg;
   assign timeout_o     = timeout_reg;
   assign proto_err_o   = proto_reg;
   assign state_o       = state_reg;
   assign last_status_o = last_reg;

endmodule

// File: tb/tb_sim_term_ctrl.sv
// Scoreboard bench for sim_term_ctrl: stimulus queues cycle-stamped expectations,
// a monitor compares them against the DUT outputs on the falling edge.
module tb_sim_term_ctrl;

   localparam logic [31:0] SA   = 32'h1000_0000;
   localparam logic [15:0] BOOT = 16'hb090;
   localparam logic [15:0] TEST = 16'h4354;
   localparam logic [15:0] WFI  = 16'h4d61;
   localparam logic [15:0] PASS = 16'h900d;
   localparam logic [15:0] FAIL = 16'hbaad;

   localparam int S_DONE = 0, S_PASSED = 1, S_TMO = 2, S_PROTO = 3, S_STATE = 4, S_LAST = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [31:0] addr;
   logic [15:0] data;
   logic [31:0] status_addr;
   logic [31:0] tmo;
   logic [7:0]  drn;
   logic        done, passed, timeout, proto_err;
   logic [2:0]  state;
   logic [15:0] last_status;

   sim_term_ctrl #(.CntW(32), .DrainW(8)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .wr_valid_i      (wr_valid),
      .addr_i          (addr),
      .data_i          (data),
      .status_addr_i   (status_addr),
      .timeout_cycles_i(tmo),
      .drain_cycles_i  (drn),
      .done_o          (done),
      .passed_o        (passed),
      .timeout_o       (timeout),
      .proto_err_o     (proto_err),
      .state_o         (state),
      .last_status_o   (last_status)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic void expect_at(input int c, input int s, input logic [31:0] v);
      exp_t e;
      int   i;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endfunction

   function automatic logic [31:0] actual(input int s);
      case (s)
         S_DONE:   return {31'd0, done};
         S_PASSED: return {31'd0, passed};
         S_TMO:    return {31'd0, timeout};
         S_PROTO:  return {31'd0, proto_err};
         S_STATE:  return {29'd0, state};
         default:  return {16'd0, last_status};
      endcase
   endfunction

   function automatic string sig_name(input int s);
      case (s)
         S_DONE:   return "done";
         S_PASSED: return "passed";
         S_TMO:    return "timeout";
         S_PROTO:  return "proto_err";
         S_STATE:  return "state";
         default:  return "last_status";
      endcase
   endfunction

   // Monitor: compare every expectation due at the current cycle.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.sig);
            vectors++;
            if (e.cyc < cyc) begin
               miscompares++;
               $display("FAIL %s: check for cycle %0d not reached (now %0d), want %0h",
                        sig_name(e.sig), e.cyc, cyc, e.val);
            end else if (act !== e.val) begin
               miscompares++;
               $display("FAIL %s @cycle %0d: got %0h, want %0h", sig_name(e.sig), cyc, act, e.val);
            end else begin
               $display("ok   %s @cycle %0d = %0h", sig_name(e.sig), cyc, act);
            end
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] d, output int n);
      n        = cyc;
      wr_valid = 1'b1;
      addr     = a;
      data     = d;
      @(negedge clk);
      wr_valid = 1'b0;
      addr     = '0;
      data     = '0;
   endtask

   task automatic do_reset();
      int r;
      r   = cyc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 6; s++) expect_at(r + 1, s, 32'd0);
   endtask

   initial begin
      int n, m, p;
      rst         = 1'b1;
      wr_valid    = 1'b0;
      addr        = '0;
      data        = '0;
      status_addr = SA;
      tmo         = '0;
      drn         = '0;
      repeat (3) @(negedge clk);
      do_reset();
      tick(1);

      // Normal pass, D=4
      tmo = 32'd1000;
      drn = 8'd4;
      wr(SA, BOOT, n);
      expect_at(n + 1, S_STATE, 1);
      expect_at(n + 1, S_LAST, BOOT);
      wr(SA, TEST, n);
      expect_at(n + 1, S_STATE, 2);
      wr(SA, PASS, n);
      expect_at(n + 1, S_STATE, 3);
      expect_at(n + 1, S_PASSED, 1);
      expect_at(n + 5, S_STATE, 3);
      expect_at(n + 5, S_DONE, 0);
      expect_at(n + 6, S_DONE, 1);
      expect_at(n + 6, S_STATE, 4);
      expect_at(n + 6, S_PASSED, 1);
      expect_at(n + 6, S_TMO, 0);
      expect_at(n + 6, S_LAST, PASS);
      tick(8);

      // Wrong address in Test: ignored, watchdog keeps running from the TEST write
      do_reset();
      tmo = 32'd20;
      drn = 8'd0;
      wr(SA, BOOT, n);
      wr(SA, TEST, n);
      tick(4);
      wr(SA + 32'd4, PASS, m);
      expect_at(m + 1, S_STATE, 2);
      expect_at(m + 1, S_LAST, TEST);
      expect_at(n + 21, S_STATE, 2);
      expect_at(n + 22, S_STATE, 3);
      expect_at(n + 22, S_TMO, 1);
      expect_at(n + 23, S_DONE, 1);
      tick(20);

      // Watchdog expiry, T=100, D=0
      do_reset();
      tmo = 32'd100;
      drn = 8'd0;
      wr(SA, TEST, n);
      expect_at(n + 101, S_STATE, 2);
      expect_at(n + 102, S_STATE, 3);
      expect_at(n + 102, S_TMO, 1);
      expect_at(n + 102, S_PASSED, 0);
      expect_at(n + 102, S_DONE, 0);
      expect_at(n + 103, S_DONE, 1);
      expect_at(n + 103, S_STATE, 4);
      tick(105);

      // Write/timeout race, T=10: WFI lands on the expiry cycle
      do_reset();
      tmo = 32'd10;
      wr(SA, TEST, n);
      tick(10);
      wr(SA, WFI, m);
      expect_at(m + 1, S_STATE, 2);
      expect_at(m + 1, S_TMO, 0);
      expect_at(m + 1, S_LAST, WFI);
      expect_at(m + 11, S_STATE, 2);
      expect_at(m + 12, S_STATE, 3);
      expect_at(m + 12, S_TMO, 1);
      tick(14);

      // Watchdog disabled: long silence never finishes
      do_reset();
      tmo = 32'd0;
      wr(SA, TEST, n);
      tick(10000);
      expect_at(cyc + 1, S_STATE, 2);
      expect_at(cyc + 1, S_DONE, 0);
      expect_at(cyc + 1, S_TMO, 0);
      tick(2);

      // Protocol error: PASS straight after BOOT, later writes ignored
      do_reset();
      tmo = 32'd0;
      drn = 8'd3;
      wr(SA, BOOT, n);
      wr(SA, PASS, n);
      expect_at(n + 1, S_STATE, 3);
      expect_at(n + 1, S_PROTO, 1);
      expect_at(n + 1, S_PASSED, 0);
      expect_at(n + 1, S_TMO, 0);
      expect_at(n + 4, S_DONE, 0);
      expect_at(n + 5, S_DONE, 1);
      tick(6);
      wr(SA, FAIL, m);
      wr(SA, TEST, m);
      expect_at(n + 10, S_STATE, 4);
      expect_at(n + 10, S_DONE, 1);
      expect_at(n + 10, S_PROTO, 1);
      expect_at(n + 10, S_PASSED, 0);
      expect_at(n + 10, S_LAST, PASS);
      tick(2);

      // Reset at cycle 50 of a 200-cycle drain, then a fresh passing run
      do_reset();
      drn = 8'd200;
      wr(SA, BOOT, n);
      wr(SA, TEST, n);
      wr(SA, PASS, n);
      expect_at(n + 1, S_STATE, 3);
      tick(49);
      do_reset();
      drn = 8'd2;
      wr(SA, BOOT, p);
      wr(SA, TEST, p);
      wr(SA, PASS, p);
      expect_at(p + 3, S_DONE, 0);
      expect_at(p + 4, S_DONE, 1);
      expect_at(p + 4, S_PASSED, 1);
      expect_at(p + 4, S_STATE, 4);
      tick(6);

      // FAIL straight from Idle
      do_reset();
      drn = 8'd0;
      wr(SA, FAIL, n);
      expect_at(n + 1, S_STATE, 3);
      expect_at(n + 1, S_PASSED, 0);
      expect_at(n + 1, S_PROTO, 0);
      expect_at(n + 1, S_LAST, FAIL);
      expect_at(n + 2, S_DONE, 1);
      expect_at(n + 2, S_STATE, 4);
      tick(4);

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard: %0d expectations never checked, want 0", sb.size());
         miscompares += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
